// File: rtl/pipe_pkg.sv
// Shared pipeline types for the MEM stage: access-size codes, the data-memory FSM
// states, and the request record captured when an access starts.
package pipe_pkg;

    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } dmem_state_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  dt;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/mem_stage_dmem_if.sv
// EX/MEM-to-data-memory bus: request fields from the pipeline register, and the
// load result / stall / completion signals returned to the pipeline.
interface mem_stage_dmem_if;

    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic [1:0]  MEM_Datatype;
    logic [31:0] MEM_ALUResult;
    logic [31:0] MEM_ReadData2;
    logic [31:0] MEM_ReadData;
    logic        Stall;
    logic        Done;

    modport master (
        output MEM_MemRead, MEM_MemWrite, MEM_Datatype, MEM_ALUResult, MEM_ReadData2,
        input  MEM_ReadData, Stall, Done
    );

    modport slave (
        input  MEM_MemRead, MEM_MemWrite, MEM_Datatype, MEM_ALUResult, MEM_ReadData2,
        output MEM_ReadData, Stall, Done
    );

endinterface

// File: rtl/dmem_lane_mux.sv
// Byte-lane steering for the data memory: store byte enables and data replication,
// load lane select and sign extension. Purely combinational.
module dmem_lane_mux
    import pipe_pkg::*;
(
    input  logic [1:0]  dt,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data_in,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] st_data,
    output logic [31:0] ld_data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];
        byte_sel = rd_word[{offset, 3'b000} +: 8];
        byte_en  = 4'b1111;
        st_data  = st_data_in;
        ld_data  = rd_word;
        case (dt)
            DT_HALF: begin
                byte_en = offset[1] ? 4'b1100 : 4'b0011;
                st_data = {2{st_data_in[15:0]}};
                ld_data = {{16{half_sel[15]}}, half_sel};
            end
            DT_BYTE: begin
                byte_en = 4'b0001 << offset;
                st_data = {4{st_data_in[7:0]}};
                ld_data = {{24{byte_sel[7]}}, byte_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory with fixed access latency; stalls upstream while busy.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module mem_stage_dmem
    import pipe_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    mem_stage_dmem_if.slave  bus
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic             MisalignErr
`endif
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dmem_state_t state, state_nxt;
    logic [3:0]  cnt;
    dmem_req_t   req_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic          request;
    logic          fire;
    logic          access_ok;
    logic [AW-1:0] word_idx;
    logic [3:0]    byte_en;
    logic [31:0]   st_data;
    logic [31:0]   ld_data;

    assign request  = bus.MEM_MemRead | bus.MEM_MemWrite;
    assign fire     = (state == ST_BUSY) && (cnt == 4'd0) && !Rst;
    assign word_idx = req_q.addr[AW+1:2];

    dmem_lane_mux u_lane_mux (
        .dt         (req_q.dt),
        .offset     (req_q.addr[1:0]),
        .st_data_in (req_q.wdata),
        .rd_word    (mem[word_idx]),
        .byte_en    (byte_en),
        .st_data    (st_data),
        .ld_data    (ld_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (request) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt == 4'd0) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.Stall = 1'b0;
        bus.Done  = 1'b0;
        case (state)
            ST_IDLE: bus.Stall = request;
            ST_BUSY: bus.Stall = 1'b1;
            ST_DONE: bus.Done  = 1'b1;
            default: ;
        endcase
        if (Rst) bus.Stall = 1'b0;
    end

    // The request is captured in IDLE so later input changes cannot disturb the access.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt              <= 4'd0;
            req_q            <= '0;
            bus.MEM_ReadData <= 32'd0;
        end else begin
            if (state == ST_IDLE && request) begin
                cnt   <= LAT_M1;
                req_q <= '{rd: bus.MEM_MemRead, wr: bus.MEM_MemWrite, dt: bus.MEM_Datatype,
                           addr: bus.MEM_ALUResult, wdata: bus.MEM_ReadData2};
            end else if (state == ST_BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (fire && access_ok && req_q.rd && !req_q.wr)
                bus.MEM_ReadData <= ld_data;
        end
    end

    // NOTE: the array is deliberately not reset; a reset port on it would prevent RAM inference.
    always_ff @(posedge Clk) begin
        if (fire && access_ok && req_q.wr) begin
            for (int i = 0; i < 4; i++)
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;

    always_comb begin
        case (req_q.dt)
            DT_HALF: misalign = req_q.addr[0];
            DT_BYTE: misalign = 1'b0;
            default: misalign = (req_q.addr[1:0] != 2'b00);
        endcase
    end

    assign access_ok = !misalign;

    always_ff @(posedge Clk) begin
        if (Rst)                  MisalignErr <= 1'b0;
        else if (fire && misalign) MisalignErr <= 1'b1;
    end
`else
    assign access_ok = 1'b1;
`endif

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Self-checking bench for mem_stage_dmem: directed vector table, reset/misalign
// sequences, and random accesses against a byte-array reference model.
module tb_mem_stage_dmem;
    import pipe_pkg::*;

    localparam int DEPTH     = 64;
    localparam int LAT       = 2;
    localparam int MEM_BYTES = DEPTH * 4;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    mem_stage_dmem_if bus ();
`ifdef DMEM_MISALIGN_TRAP_EN
    logic MisalignErr;
`endif

    mem_stage_dmem #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .MisalignErr (MisalignErr)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mdl [MEM_BYTES];
    logic [31:0] mdl_rdata;
    bit          mdl_err;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  dt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: memory as a flat little-endian byte array.
    task automatic model_apply(input logic rd, input logic wr, input logic [1:0] dt,
                               input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned sz, a;
        logic [31:0] v;
        sz = (dt == DT_HALF) ? 2 : (dt == DT_BYTE) ? 1 : 4;
        a  = addr;
        if (a % sz != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            mdl_err = 1'b1;
            return;
`else
            a = a - a % sz;
`endif
        end
        a = a % MEM_BYTES;
        if (wr) begin
            for (int k = 0; k < int'(sz); k++) mdl[a + k] = 8'(wdata >> (8 * k));
        end else if (rd) begin
            v = 32'd0;
            for (int k = 0; k < int'(sz); k++) v = v | (32'(mdl[a + k]) << (8 * k));
            if (sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
            mdl_rdata = v;
        end
    endtask

    task automatic run_access(input string name, input logic rd, input logic wr, input logic [1:0] dt,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata);
        int stalls;
        bit done_seen;
        @(negedge Clk);
        bus.MEM_MemRead   = rd;
        bus.MEM_MemWrite  = wr;
        bus.MEM_Datatype  = dt;
        bus.MEM_ALUResult = addr;
        bus.MEM_ReadData2 = wdata;
        stalls    = 0;
        done_seen = 1'b0;
        rdata     = 32'd0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.Stall) stalls++;
            if (bus.Done) begin
                done_seen = 1'b1;
                rdata     = bus.MEM_ReadData;
                break;
            end
            @(negedge Clk);
        end
        bus.MEM_MemRead  = 1'b0;
        bus.MEM_MemWrite = 1'b0;
        check({name, " done"}, 32'(done_seen), 32'd1);
        check({name, " stall_cycles"}, 32'(stalls), 32'(LAT + 1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd_val;
        logic [31:0] exp_val;
        int          sel;
        logic [1:0]  rdt;
        logic [31:0] raddr, rwdata;

        Rst               = 1'b1;
        bus.MEM_MemRead   = 1'b0;
        bus.MEM_MemWrite  = 1'b0;
        bus.MEM_Datatype  = DT_WORD;
        bus.MEM_ALUResult = 32'd0;
        bus.MEM_ReadData2 = 32'd0;
        mdl_rdata         = 32'd0;
        mdl_err           = 1'b0;

        // Reset state, including Stall held low despite a pending request.
        repeat (2) @(negedge Clk);
        bus.MEM_MemRead = 1'b1;
        #1 check("stall_low_in_reset", 32'(bus.Stall), 32'd0);
        @(negedge Clk);
        bus.MEM_MemRead = 1'b0;
        Rst = 1'b0;
        #1;
        check("reset_stall", 32'(bus.Stall), 32'd0);
        check("reset_done", 32'(bus.Done), 32'd0);
        check("reset_rdata", bus.MEM_ReadData, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("reset_misalign", 32'(MisalignErr), 32'd0);
`endif

        // Preload every word with a known pattern.
        for (int i = 0; i < DEPTH; i++) begin
            run_access($sformatf("init%0d", i), 1'b0, 1'b1, DT_WORD, 32'(4 * i), 32'hC0DE_0000 + 32'(i), rd_val);
            model_apply(1'b0, 1'b1, DT_WORD, 32'(4 * i), 32'hC0DE_0000 + 32'(i));
        end

        vecs[0]  = '{1'b0, 1'b1, DT_WORD, 32'h10,  32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, DT_WORD, 32'h10,  32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, DT_BYTE, 32'h13,  32'h0000_0080, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 1'b0, DT_BYTE, 32'h13,  32'h0,         32'hFFFF_FF80};
        vecs[4]  = '{1'b1, 1'b0, DT_WORD, 32'h10,  32'h0,         32'h80AD_BEEF};
        vecs[5]  = '{1'b0, 1'b1, DT_HALF, 32'h16,  32'h0000_1234, 32'h80AD_BEEF};
        vecs[6]  = '{1'b1, 1'b0, DT_HALF, 32'h16,  32'h0,         32'h0000_1234};
        vecs[7]  = '{1'b1, 1'b0, DT_WORD, 32'h14,  32'h0,         32'h1234_0005};
        vecs[8]  = '{1'b1, 1'b1, DT_WORD, 32'h08,  32'h0000_0055, 32'h1234_0005};
        vecs[9]  = '{1'b1, 1'b0, DT_WORD, 32'h08,  32'h0,         32'h0000_0055};
        vecs[10] = '{1'b1, 1'b0, DT_BYTE, 32'h11,  32'h0,         32'hFFFF_FFBE};
        vecs[11] = '{1'b1, 1'b0, DT_HALF, 32'h12,  32'h0,         32'hFFFF_80AD};
        vecs[12] = '{1'b1, 1'b0, DT_BYTE, 32'h12,  32'h0,         32'hFFFF_FFAD};
        vecs[13] = '{1'b1, 1'b0, DT_BYTE, 32'h08,  32'h0,         32'h0000_0055};
        vecs[14] = '{1'b1, 1'b0, 2'b11,   32'h10,  32'h0,         32'h80AD_BEEF};
        vecs[15] = '{1'b1, 1'b0, DT_WORD, 32'h110, 32'h0,         32'h80AD_BEEF};

        for (int i = 0; i < 16; i++) begin
            run_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].dt,
                       vecs[i].addr, vecs[i].wdata, rd_val);
            model_apply(vecs[i].rd, vecs[i].wr, vecs[i].dt, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d rdata", i), rd_val, vecs[i].exp);
        end

        // Reset during BUSY abandons the pending store.
        @(negedge Clk);
        bus.MEM_MemWrite  = 1'b1;
        bus.MEM_Datatype  = DT_WORD;
        bus.MEM_ALUResult = 32'h20;
        bus.MEM_ReadData2 = 32'hBAD0_BAD0;
        #1 check("rstseq stall_idle", 32'(bus.Stall), 32'd1);
        @(negedge Clk);
        #1 check("rstseq stall_busy", 32'(bus.Stall), 32'd1);
        Rst = 1'b1;
        #1 check("rstseq stall_forced", 32'(bus.Stall), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        bus.MEM_MemWrite = 1'b0;
        #1;
        check("rstseq stall_after", 32'(bus.Stall), 32'd0);
        check("rstseq done_after", 32'(bus.Done), 32'd0);
        check("rstseq rdata_cleared", bus.MEM_ReadData, 32'd0);
        mdl_rdata = 32'd0;
        mdl_err   = 1'b0;
        run_access("rstseq load", 1'b1, 1'b0, DT_WORD, 32'h20, 32'h0, rd_val);
        model_apply(1'b1, 1'b0, DT_WORD, 32'h20, 32'h0);
        check("rstseq load rdata", rd_val, 32'hC0DE_0008);

        // Misaligned word store, then loads observing its effect.
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis err_before", 32'(MisalignErr), 32'd0);
`endif
        run_access("mis store", 1'b0, 1'b1, DT_WORD, 32'h2, 32'h1122_3344, rd_val);
        model_apply(1'b0, 1'b1, DT_WORD, 32'h2, 32'h1122_3344);
`ifdef DMEM_MISALIGN_TRAP_EN
        #1 check("mis err_after", 32'(MisalignErr), 32'd1);
        exp_val = 32'hC0DE_0000;
`else
        exp_val = 32'h1122_3344;
`endif
        run_access("mis load0", 1'b1, 1'b0, DT_WORD, 32'h0, 32'h0, rd_val);
        model_apply(1'b1, 1'b0, DT_WORD, 32'h0, 32'h0);
        check("mis load0 rdata", rd_val, exp_val);
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_val = 32'hC0DE_0000;
`else
        exp_val = 32'hFFFF_BEEF;
`endif
        run_access("mis half", 1'b1, 1'b0, DT_HALF, 32'h11, 32'h0, rd_val);
        model_apply(1'b1, 1'b0, DT_HALF, 32'h11, 32'h0);
        check("mis half rdata", rd_val, exp_val);

        // Random traffic against the reference model.
        for (int i = 0; i < 150; i++) begin
            sel    = int'($urandom_range(0, 2));
            rdt    = 2'($urandom_range(0, 3));
            raddr  = 32'($urandom_range(0, 2 * MEM_BYTES - 1));
            rwdata = $urandom;
            run_access($sformatf("rnd%0d", i), sel != 1, sel != 0, rdt, raddr, rwdata, rd_val);
            model_apply(sel != 1, sel != 0, rdt, raddr, rwdata);
            check($sformatf("rnd%0d rdata", i), rd_val, mdl_rdata);
        end

        // No request: outputs stay quiet.
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            #1;
            check($sformatf("idle%0d stall", i), 32'(bus.Stall), 32'd0);
            check($sformatf("idle%0d done", i), 32'(bus.Done), 32'd0);
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        check("final misalign", 32'(MisalignErr), 32'(mdl_err));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_dmem.md
# mem_stage_dmem

MEM-stage data memory unit, directly downstream of the EX/MEM pipeline register. Performs word, halfword and byte loads/stores on a word-organised on-chip array with a fixed, configurable access latency. Asserts `Stall` so that the EX/MEM register (`Ld = !Stall`) and all earlier stages hold while an access is in flight. Returns sign-extended load data registered for the MEM/WB register.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two.
- `LATENCY`, 2: access latency in cycles, legal range 1–15.

Ports:
- `Clk`  in  1  clock.
- `Rst`  in  1  reset, synchronous, active-high.
- `MEM_MemRead`  in  1  load request.
- `MEM_MemWrite`  in  1  store request.
- `MEM_Datatype`  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- `MEM_ALUResult`  in  32  byte address.
- `MEM_ReadData2`  in  32  store data; low bits are used for sub-word stores.
- `MEM_ReadData`  out  32  registered load result.
- `Stall`  out  1  hold upstream pipeline.
- `Done`  out  1  one-cycle pulse when an access completes.
- `MisalignErr`  out  1  sticky flag; exists only under the trap macro.

## Operation
- FSM states are IDLE, BUSY and DONE. A request is `MEM_MemRead | MEM_MemWrite`.
- In IDLE with a request: `Stall`=1 combinationally; `cnt <= LATENCY-1`; go to BUSY.
- In IDLE with no request: `Stall`=0.
- In BUSY: `Stall`=1.
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, perform the array access at this edge and go to DONE.
- In DONE: `Stall`=0 and `Done`=1. Go to IDLE. EX/MEM advances at this edge.
- Word index is `MEM_ALUResult[log2(DEPTH_WORDS)+1:2]`. Addresses out of range wrap modulo the depth.
- Byte order is little-endian: byte offset 0 maps to bits [7:0].
- Store byte enables:
  - word: all four lanes.
  - half: lanes {1,0} when `addr[1]`=0, lanes {3,2} when `addr[1]`=1.
  - byte: the lane selected by `addr[1:0]`.
  - Sub-word store data is replicated from `MEM_ReadData2[15:0]` or `[7:0]`.
- Loads: the selected half or byte is sign-extended to 32 bits. A word load is passed through unchanged.
- `MEM_ReadData` updates only on a completing load and holds otherwise.
- Read and write asserted together: the write is performed, `MEM_ReadData` is unchanged, and timing is the same as a single access.
- Request inputs are sampled only in IDLE. Changes during BUSY are ignored; upstream is stalled, so inputs are stable anyway.
- Array contents are not reset.

## Timing
- Reset values: FSM=IDLE, `cnt`=0, `MEM_ReadData`=0, `Done`=0, `MisalignErr`=0. `Stall` is forced to 0 while `Rst`=1.
- For each access, `Stall` is high for LATENCY+1 cycles and `Done` is high for 1 cycle. The instruction occupies MEM for LATENCY+2 cycles.
- Load data is valid in DONE, the cycle `Done`=1, and persists until the next load completes.
- Back-to-back requests: after DONE the FSM passes through IDLE, where the next request is seen immediately. There are no idle bubbles beyond DONE.
- Reset mid-access goes to IDLE. The pending store is abandoned because the array write occurs only at the final BUSY edge.
- No request: `Stall`=0 and `Done`=0 permanently.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A misaligned access sets sticky `MisalignErr`, cleared only by `Rst`. Misaligned means a word with `addr[1:0]`≠0, or a half with `addr[0]`=1.
  - A misaligned store writes nothing. A misaligned load leaves `MEM_ReadData` unchanged.
  - Timing is unchanged.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - No `MisalignErr` port.
  - Low address bits are forced aligned: [1:0]=0 for word, [0]=0 for half.

## Structure
- Shared package `pipe_pkg`:
  - Datatype constants `DT_WORD`, `DT_HALF`, `DT_BYTE`.
  - FSM state enum `dmem_state_t`.
- Sub-module `dmem_lane_mux`, combinational:
  - Byte-enable and store-data replication.
  - Load lane select and sign extension.
- The FSM and array stay in the top module.

## Test plan
- LATENCY=2, word store 0xDEADBEEF @0x10, then word load @0x10 → `Stall` high 3 cycles per access, `Done` pulses, `MEM_ReadData`=0xDEADBEEF.
- Byte store 0x80 @0x13, then byte load @0x13 → `MEM_ReadData`=0xFFFFFF80. Word load @0x10 → 0x80ADBEEF.
- Halfword store 0x1234 @0x16, then half load @0x16 → 0x00001234. Word @0x14 → upper half 0x1234, lower half unchanged.
- Store to @0x20 with `Rst` pulsed during BUSY → FSM IDLE, `Stall`=0, a later load @0x20 returns the prior contents.
- Read+write together @0x8 with data 0x55 → array word=0x55, `MEM_ReadData` unchanged.
- With `DMEM_MISALIGN_TRAP_EN`, word store @0x2 → `MisalignErr`=1 and array untouched. Without the macro, the same store writes word @0x0.
